// File: rtl/onchip_mem_test_pkg.sv
// Shared types and defaults for the on-chip memory test master.
package onchip_mem_test_pkg;

  localparam int ERR_W      = 16;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 10000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/onchip_mem_test_checker.sv
// Compares returned read data against the expected pattern; counts mismatches
// (saturating) and remembers the address of the first one in a run.
module onchip_mem_test_checker
  import onchip_mem_test_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              cmp_valid,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] act_data,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;

  always_comb begin
    err_d   = err_q;
    first_d = first_q;
    if (clear) begin
      err_d   = '0;
      first_d = '0;
    end else if (cmp_valid && (exp_data != act_data)) begin
      if (err_q != '1) err_d = err_q + ERR_W'(1);
      if (err_q == '0) first_d = cmp_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= '0;
      first_q <= '0;
    end else begin
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: rtl/onchip_mem_test_master.sv
// Avalon-MM memory test master: writes seed+a to words 0..N-1, reads them
// back-to-back and checks each word one cycle later.
module onchip_mem_test_master
  import onchip_mem_test_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   length,
  input  logic [DATA_W-1:0]   seed,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [2:0]          dbg_state
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              pass_q, pass_d;
  logic              clear;
  logic [ADDR_W-1:0] n_clamp;
  logic              last;

  // Expected-value pipe aligned with the 1-cycle read latency of the slave.
  logic              rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_exp_q, rd_exp_d;

  assign n_clamp = (32'(length) > DEPTH) ? ADDR_W'(DEPTH) : length;
  assign last    = (addr_q == n_q - ADDR_W'(1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    n_d     = n_q;
    seed_d  = seed_q;
    pass_d  = pass_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n_clamp;
          seed_d  = seed;
          addr_d  = '0;
          pass_d  = 1'b0;
          clear   = 1'b1;
          state_d = (n_clamp == '0) ? FINISH : WRITE;
        end
      end
      WRITE: begin
        if (last) begin
          addr_d  = '0;
          state_d = READ;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      READ: begin
        if (last) begin
          addr_d  = '0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DRAIN: state_d = FINISH;
      FINISH: begin
        pass_d  = (err_count == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_vld_d  = (state_q == READ);
    rd_addr_d = addr_q;
    rd_exp_d  = seed_q + DATA_W'(addr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      n_q       <= '0;
      seed_q    <= '0;
      pass_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_exp_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      n_q       <= n_d;
      seed_q    <= seed_d;
      pass_q    <= pass_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      rd_exp_q  <= rd_exp_d;
    end
  end

  onchip_mem_test_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_checker (
    .clk           (clk),
    .rst           (reset),
    .clear         (clear),
    .cmp_valid     (rd_vld_q),
    .exp_data      (rd_exp_q),
    .act_data      (readdata),
    .cmp_addr      (rd_addr_q),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

  assign chipselect = (state_q == WRITE) || (state_q == READ);
  assign write      = (state_q == WRITE);
  assign address    = addr_q;
  assign byteenable = chipselect ? '1 : '0;
  assign writedata  = write ? (seed_q + DATA_W'(addr_q)) : '0;
  assign clken      = 1'b1;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  // pass is already valid alongside done, then held in IDLE.
  assign pass       = (state_q == FINISH) ? (err_count == '0) : pass_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_onchip_mem_test_master.sv
// Bench for onchip_mem_test_master: 1-cycle RAM model, table of runs,
// access scoreboard, and hand-written reset/retrigger sequences.
module tb_onchip_mem_test_master;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int W  = AW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] length;
  logic [DW-1:0] seed;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          write;
  logic [DW-1:0] writedata;
  logic          clken;
  logic [DW-1:0] readdata = '0;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  onchip_mem_test_master dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .length        (length),
    .seed          (seed),
    .address       (address),
    .byteenable    (byteenable),
    .chipselect    (chipselect),
    .write         (write),
    .writedata     (writedata),
    .clken         (clken),
    .readdata      (readdata),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_addr(first_err_addr),
    .dbg_state     (dbg_state)
  );

  // RAM model with optional read corruption per address.
  logic [DW-1:0] mem [0:16383];
  logic          bad [0:16383];

  always @(posedge clk) begin
    if (chipselect && write) mem[address] <= writedata;
    if (chipselect && !write)
      readdata <= mem[address] ^ (bad[address] ? 32'h0000_0100 : 32'h0);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected accesses: writes as {addr,data}, reads as addr.
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] rd_q[$];
  int            cs_cnt;
  int            max_addr;

  always @(negedge clk) begin
    if (!reset && chipselect) begin
      cs_cnt++;
      if (int'(address) > max_addr) max_addr = int'(address);
      check("byteenable", byteenable, 4'hF);
      if (write) begin
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else check("write_addr_data", {address, writedata}, exp_q.pop_front());
      end else begin
        if (rd_q.size() == 0) check("unexpected_read", 1, 0);
        else check("read_addr", address, rd_q.pop_front());
      end
    end
  end

  typedef struct {
    logic [AW-1:0] len;
    logic [DW-1:0] seed;
    int            bad_a;
    int            bad_b;
    bit            retrig;
    int            cyc;
    int            err;
    int            first;
    bit            pass;
  } vec_t;

  vec_t vecs[7];

  task automatic load_scoreboard(input int n, input logic [DW-1:0] s);
    exp_q.delete();
    rd_q.delete();
    for (int a = 0; a < n; a++) begin
      exp_q.push_back({AW'(a), s + DW'(a)});
      rd_q.push_back(AW'(a));
    end
    cs_cnt   = 0;
    max_addr = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_address"}, address, 0);
    check({tag, "_byteenable"}, byteenable, 0);
    check({tag, "_chipselect"}, chipselect, 0);
    check({tag, "_write"}, write, 0);
    check({tag, "_writedata"}, writedata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_first_err_addr"}, first_err_addr, 0);
    check({tag, "_clken"}, clken, 1);
  endtask

  task automatic run_row(input int idx, input vec_t v);
    int n;
    int cyc;
    n = (int'(v.len) > 10000) ? 10000 : int'(v.len);
    for (int i = 0; i < 16384; i++) bad[i] = 1'b0;
    if (v.bad_a >= 0) bad[v.bad_a] = 1'b1;
    if (v.bad_b >= 0) bad[v.bad_b] = 1'b1;
    load_scoreboard(n, v.seed);
    @(negedge clk);
    length = v.len;
    seed   = v.seed;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 30000) begin
      if (v.retrig && cyc == 3) begin
        length = 14'd20;
        seed   = 32'hDEAD_0000;
        start  = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (!done) begin
      check($sformatf("row%0d_done_timeout", idx), 0, 1);
    end else begin
      check($sformatf("row%0d_cycles", idx), cyc + 1, v.cyc);
      check($sformatf("row%0d_err_count", idx), err_count, v.err);
      check($sformatf("row%0d_first_err_addr", idx), first_err_addr, v.first);
      check($sformatf("row%0d_pass_at_done", idx), pass, v.pass);
      check($sformatf("row%0d_busy_at_done", idx), busy, 1);
    end
    check($sformatf("row%0d_cs_count", idx), cs_cnt, 2 * n);
    if (n > 0) check($sformatf("row%0d_max_addr", idx), max_addr, n - 1);
    check($sformatf("row%0d_writes_left", idx), exp_q.size(), 0);
    check($sformatf("row%0d_reads_left", idx), rd_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    check($sformatf("row%0d_idle_busy", idx), busy, 0);
    check($sformatf("row%0d_idle_done", idx), done, 0);
    check($sformatf("row%0d_pass_hold", idx), pass, v.pass);
    check($sformatf("row%0d_err_hold", idx), err_count, v.err);
  endtask

  initial begin
    int found;
    vec_t r;
    reset  = 1'b1;
    start  = 1'b0;
    length = '0;
    seed   = '0;
    cs_cnt = 0;
    max_addr = -1;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = '0;
      bad[i] = 1'b0;
    end

    vecs[0] = '{14'd16,     32'h1000_0000, -1, -1, 1'b0, 34,    0, 0, 1'b1};
    vecs[1] = '{14'd16,     32'h1000_0000,  5,  9, 1'b0, 34,    2, 5, 1'b0};
    vecs[2] = '{14'd0,      32'h1234_5678, -1, -1, 1'b0, 1,     0, 0, 1'b1};
    vecs[3] = '{14'd1,      32'hFFFF_FFFF, -1, -1, 1'b0, 4,     0, 0, 1'b1};
    vecs[4] = '{14'd8,      32'hA5A5_0000, -1, -1, 1'b1, 18,    0, 0, 1'b1};
    vecs[5] = '{14'd3,      32'hFFFF_FFFE,  2, -1, 1'b0, 8,     1, 2, 1'b0};
    vecs[6] = '{14'h3FFF,   $urandom,      -1, -1, 1'b0, 20002, 0, 0, 1'b1};

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_por");

    for (int i = 0; i < 7; i++) run_row(i, vecs[i]);

    // Reset during READ at a=7, then a clean short run.
    for (int i = 0; i < 16384; i++) bad[i] = 1'b0;
    load_scoreboard(16, 32'h0BAD_F00D);
    @(negedge clk);
    length = 14'd16;
    seed   = 32'h0BAD_F00D;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clk);
      if (chipselect && !write && address == 14'd7) found = 1;
    end
    check("found_read_a7", found, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrun");
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    rd_q.delete();
    @(negedge clk);
    check_reset_outputs("post_midrun");
    r = '{14'd4, 32'h7777_0000, -1, -1, 1'b0, 10, 0, 0, 1'b1};
    run_row(7, r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
